// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing generator plus framebuffer fetcher.
// Reads packed RGB332 pixels (4 per word) from shared video RAM over a
// request/grant port, buffers whole words in a small FIFO and emits
// registered pixel, sync and data-enable outputs on the pixel clock.
module vga_scanout #(
  parameter int WIDTH      = 32,
  parameter int FB_BASE    = 0,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] address,
  output logic             fb_req,
  input  logic             fb_gnt,
  input  logic [WIDTH-1:0] data_in,
  output logic [7:0]       pixel,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             underflow
);

  localparam int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W         = $clog2(H_TOTAL + 1);
  localparam int V_W         = $clog2(V_TOTAL + 1);
  localparam int A_W         = $clog2(FIFO_DEPTH);
  localparam int C_W         = A_W + 1;
  localparam int O_W         = C_W + 1;
  localparam int TOTAL_WORDS = H_VISIBLE * V_VISIBLE / 4;

  localparam logic [H_W-1:0]   H_VIS_C    = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0]   H_LAST_C   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   HS_START_C = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0]   HS_END_C   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0]   V_VIS_C    = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0]   V_LAST_C   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   VS_START_C = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0]   VS_END_C   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [WIDTH-1:0] BASE_C     = WIDTH'(FB_BASE);
  localparam logic [WIDTH-1:0] TOTAL_C    = WIDTH'(TOTAL_WORDS);
  localparam logic [O_W-1:0]   DEPTH_C    = O_W'(FIFO_DEPTH);

  // raster position
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic [1:0]       sub;

  // word FIFO and fetch bookkeeping
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [A_W-1:0]   wr_ptr;
  logic [A_W-1:0]   rd_ptr;
  logic [C_W-1:0]   count;
  logic             inflight;
  logic [WIDTH-1:0] word_idx;
  logic [WIDTH-1:0] words_left;
  // words whose display slot passed while the FIFO was empty; that many
  // returning reads are thrown away so the picture resumes column-correct
  logic [WIDTH-1:0] skip;

  logic             visible;
  logic             restart;
  logic             accept;
  logic             fifo_empty;
  logic             slot_end;
  logic             miss;
  logic             pop;
  logic             drop;
  logic             push;
  logic [C_W-1:0]   count_next;
  logic [WIDTH-1:0] word_idx_next;
  logic [WIDTH-1:0] words_left_next;
  logic [O_W-1:0]   occ_next;
  logic             req_next;
  logic [7:0]       head_byte;

  // decode raster state and work out this cycle's FIFO traffic
  always_comb begin
    visible         = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    restart         = (h_cnt == '0) && (v_cnt == V_VIS_C);
    accept          = fb_req && fb_gnt;
    fifo_empty      = (count == '0);
    slot_end        = visible && (sub == 2'd3);
    miss            = slot_end && fifo_empty;
    pop             = slot_end && !fifo_empty;
    drop            = inflight && ((skip != '0) || miss);
    push            = inflight && !drop;
    count_next      = count;
    if (push) count_next = count_next + C_W'(1);
    if (pop)  count_next = count_next - C_W'(1);
    word_idx_next   = word_idx;
    words_left_next = words_left;
    if (accept) begin
      word_idx_next   = word_idx + WIDTH'(1);
      words_left_next = words_left - WIDTH'(1);
    end
    occ_next  = {1'b0, count_next} + {{C_W{1'b0}}, accept};
    req_next  = (occ_next < DEPTH_C) && (words_left_next != '0);
    head_byte = 8'h00;
    case (sub)
      2'd0: head_byte = mem[rd_ptr][7:0];
      2'd1: head_byte = mem[rd_ptr][15:8];
      2'd2: head_byte = mem[rd_ptr][23:16];
      2'd3: head_byte = mem[rd_ptr][31:24];
      default: head_byte = 8'h00;
    endcase
  end

  // horizontal and vertical raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_C) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  // fetcher: request generation, FIFO pointers, frame restart at vblank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      word_idx   <= '0;
      words_left <= TOTAL_C;
      skip       <= '0;
      fb_req     <= 1'b0;
      address    <= BASE_C;
    end else if (restart) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      word_idx   <= '0;
      words_left <= TOTAL_C;
      skip       <= '0;
      fb_req     <= (TOTAL_C != '0);
      address    <= BASE_C;
    end else begin
      if (push) wr_ptr <= wr_ptr + A_W'(1);
      if (pop)  rd_ptr <= rd_ptr + A_W'(1);
      count      <= count_next;
      inflight   <= accept;
      word_idx   <= word_idx_next;
      words_left <= words_left_next;
      if (miss && !drop)
        skip <= skip + WIDTH'(1);
      else if (drop && !miss)
        skip <= skip - WIDTH'(1);
      fb_req     <= req_next;
      address    <= BASE_C + word_idx_next;
    end
  end

  // FIFO storage; returning read data lands here one cycle after accept
  always_ff @(posedge clk) begin
    if (push && !restart)
      mem[wr_ptr] <= data_in;
  end

  // registered video outputs, one cycle behind the raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel     <= 8'h00;
      de        <= 1'b0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      underflow <= 1'b0;
      sub       <= 2'd0;
    end else begin
      de    <= visible;
      hsync <= !((h_cnt >= HS_START_C) && (h_cnt < HS_END_C));
      vsync <= !((v_cnt >= VS_START_C) && (v_cnt < VS_END_C));
      if (visible) begin
        pixel <= fifo_empty ? 8'h00 : head_byte;
        if (fifo_empty) underflow <= 1'b1;
        sub   <= sub + 2'd1;
      end else begin
        pixel <= 8'h00;
        if (restart) sub <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench for vga_scanout on a shrunken raster.
// A reference raster counter predicts sync/de/pixel for every cycle; the
// expected pixel stream goes through a scoreboard queue and each accepted
// read address is checked against the expected word sequence.
module tb_vga_scanout;

  localparam int H_VIS   = 16;
  localparam int H_FP    = 2;
  localparam int H_SW    = 4;
  localparam int H_BP    = 2;
  localparam int V_VIS   = 6;
  localparam int V_FP    = 1;
  localparam int V_SW    = 2;
  localparam int V_BP    = 1;
  localparam int H_TOT   = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SW + V_BP;
  localparam int FRAME   = H_TOT * V_TOT;
  localparam int TOTAL   = H_VIS * V_VIS / 4;
  localparam logic [31:0] BASE = 32'h0000_0100;

  typedef struct {
    logic [7:0] val;
    logic       lenient;
  } exp_pix_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fb_gnt = 1'b0;
  logic [31:0] data_in = 32'hDEAD_BEEF;
  logic [31:0] address;
  logic        fb_req;
  logic [7:0]  pixel;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        underflow;

  int checks = 0;
  int failures = 0;

  // reference raster and fetch model state
  int          bh = 0;
  int          bv = 0;
  int          n_words = 0;
  logic        first_frame = 1'b1;
  logic        after_restart = 1'b0;
  logic        rd_pending = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        exp_de = 1'b0;
  logic        exp_hs = 1'b1;
  logic        exp_vs = 1'b1;
  logic        vis;
  logic        lenient_starve = 1'b0;
  int          black_seen = 0;
  exp_pix_t    sb[$];
  exp_pix_t    got;

  vga_scanout #(
    .WIDTH(32), .FB_BASE(32'h100),
    .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SW), .H_BACK(H_BP),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .fb_req(fb_req),
    .fb_gnt(fb_gnt), .data_in(data_in), .pixel(pixel), .hsync(hsync),
    .vsync(vsync), .de(de), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // RAM contents: word k holds the four pixel indices 4k..4k+3 (mod 256)
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] k;
    logic [7:0]  b;
    k = a - BASE;
    b = 8'(k * 4);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_fb_req"}, 32'(fb_req), 0);
    checkOutput({tag, "_address"}, address, BASE);
    checkOutput({tag, "_pixel"}, 32'(pixel), 0);
    checkOutput({tag, "_de"}, 32'(de), 0);
    checkOutput({tag, "_hsync"}, 32'(hsync), 1);
    checkOutput({tag, "_vsync"}, 32'(vsync), 1);
    checkOutput({tag, "_underflow"}, 32'(underflow), 0);
  endtask

  task automatic applyStimulus(input logic rst_v, input logic gnt_v);
    reset  = rst_v;
    fb_gnt = gnt_v;
  endtask

  task automatic waitRaster(input int line, input int col, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (bv == line && bh == col) found = 1'b1;
    end
    checkOutput(tag, 32'(found), 1);
  endtask

  // reference raster: predicts outputs, pushes expected pixels, checks reads
  always @(posedge clk) begin
    if (reset) begin
      bh = 0; bv = 0; n_words = 0; first_frame = 1'b1; after_restart = 1'b0;
      rd_pending = 1'b0; exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
      sb.delete();
    end else begin
      if (n_words == TOTAL) checkOutput("req_after_last", 32'(fb_req), 0);
      if (after_restart) checkOutput("addr_restart", address, BASE);
      after_restart = 1'b0;
      rd_pending = fb_req && fb_gnt;
      rd_addr    = address;
      if (bh == 0 && bv == V_VIS) begin
        n_words = 0;
        after_restart = 1'b1;
      end else if (fb_req && fb_gnt) begin
        checkOutput("accept_addr", address, BASE + 32'(n_words));
        n_words++;
      end
      vis    = (bh < H_VIS) && (bv < V_VIS);
      exp_de = vis;
      exp_hs = !((bh >= H_VIS + H_FP) && (bh < H_VIS + H_FP + H_SW));
      exp_vs = !((bv >= V_VIS + V_FP) && (bv < V_VIS + V_FP + V_SW));
      if (vis)
        sb.push_back('{val: 8'(bv * H_VIS + bh),
                       lenient: lenient_starve || (first_frame && bv == 0 && bh < 4)});
      if (bh == H_TOT - 1) begin
        bh = 0;
        if (bv == V_TOT - 1) begin
          bv = 0;
          first_frame = 1'b0;
        end else begin
          bv++;
        end
      end else begin
        bh++;
      end
    end
  end

  // RAM read data and output checks, away from the active edge
  always @(negedge clk) begin
    data_in = rd_pending ? ram_word(rd_addr) : 32'hDEAD_BEEF;
    checkOutput("de", 32'(de), 32'(exp_de));
    checkOutput("hsync", 32'(hsync), 32'(exp_hs));
    checkOutput("vsync", 32'(vsync), 32'(exp_vs));
    if (de === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("sb_nonempty", 32'(sb.size()), 1);
      end else begin
        got = sb.pop_front();
        if (got.lenient && pixel === 8'h00)
          black_seen++;
        else
          checkOutput("pixel", 32'(pixel), 32'(got.val));
      end
    end else begin
      checkOutput("pixel_blank", 32'(pixel), 0);
    end
  end

  initial begin
    bit found;
    $display("[TB] vga_scanout bench start");
    applyStimulus(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1 checkReset("por");

    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    repeat (2 * FRAME) @(negedge clk);
    checkOutput("underflow_startup", 32'(underflow), 1);

    waitRaster(2, 4, "wait_starve_start");
    black_seen = 0;
    lenient_starve = 1'b1;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= 20) checkOutput("req_held", 32'(fb_req), 1);
    end
    applyStimulus(1'b0, 1'b1);
    waitRaster(5, 0, "wait_starve_end");
    lenient_starve = 1'b0;
    checkOutput("black_seen", 32'(black_seen > 0), 1);
    checkOutput("underflow_sticky", 32'(underflow), 1);

    repeat (FRAME) @(negedge clk);

    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      @(negedge clk);
      if (fb_req === 1'b1 && fb_gnt === 1'b1) found = 1'b1;
    end
    checkOutput("wait_accept", 32'(found), 1);
    @(posedge clk);
    #7 applyStimulus(1'b1, 1'b1);
    #1 checkReset("midread");
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    repeat (FRAME + 40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
